// File: rtl/obuf_pkg.sv
// Shared types and arithmetic helpers for the banked output accumulation buffer.
package obuf_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_BIAS  = 2'd1,
    MODE_ACCUM = 2'd2,
    MODE_DRAIN = 2'd3
  } obuf_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_ACCUM,
    ST_ACC_FLUSH,
    ST_DRAIN,
    ST_DRAIN_FLUSH
  } obuf_state_e;

  // Saturating add of two w-bit signed values carried sign-extended in 64 bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w,
                                                  output logic clamped);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = {a[63], a} + {b[63], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    clamped = 1'b0;
    if (s > hi) begin
      clamped = 1'b1;
      s = hi;
    end else if (s < lo) begin
      clamped = 1'b1;
      s = lo;
    end
    return s[63:0];
  endfunction

  function automatic logic signed [63:0] relu(input logic signed [63:0] x);
    return (x < 64'sd0) ? 64'sd0 : x;
  endfunction

endpackage

// File: rtl/output_accum_buffer_if.sv
// Bias stream, partial-sum port and drain stream of the output accumulation buffer.
interface output_accum_buffer_if #(
  parameter int DW         = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int BW         = 4
);
  logic signed [DW-1:0]   s_bias_tdata;
  logic                   s_bias_tvalid;
  logic                   s_bias_tready;
  logic                   s_bias_tlast;

  logic                   acc_valid;
  logic                   acc_ready;
  logic [BW-1:0]          acc_bank;
  logic [ADDR_WIDTH-1:0]  acc_addr;
  logic signed [DW-1:0]   acc_data;

  logic signed [DW-1:0]   m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic                   m_tlast;

  modport master (
    output s_bias_tdata, s_bias_tvalid, s_bias_tlast,
    input  s_bias_tready,
    output acc_valid, acc_bank, acc_addr, acc_data,
    input  acc_ready,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );

  modport slave (
    input  s_bias_tdata, s_bias_tvalid, s_bias_tlast,
    output s_bias_tready,
    input  acc_valid, acc_bank, acc_addr, acc_data,
    output acc_ready,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );
endinterface

// File: rtl/obuf_bank_sdp.sv
// One accumulator bank: simple dual-port RAM, write port A, registered read port B.
module obuf_bank_sdp #(
  parameter int DW         = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic signed [DW-1:0]  wdata_a,
  input  logic                  en_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic signed [DW-1:0]  rdata_b
);
  logic signed [DW-1:0] mem [DEPTH];

  // Read-first on a same-address collision; the accumulator forwards around it.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (en_b) rdata_b <= mem[addr_b];
  end
endmodule

// File: rtl/output_accum_buffer.sv
// Banked output buffer: bias load, pipelined read-modify-write accumulation with
// same-address forwarding, and skid-buffered AXI-Stream drain.
module output_accum_buffer
  import obuf_pkg::*;
#(
  parameter int DW         = 16,
  parameter int NUM_BANKS  = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512,
  parameter int BW         = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_mode,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic                  cfg_relu,
  input  logic                  acc_end,
  output logic                  busy,
  output logic                  done,
  output logic                  err_sat,
  output_accum_buffer_if.slave  bus
);
  localparam int CW = ADDR_WIDTH + 1 + BW;

  obuf_state_e           state;
  obuf_mode_e            mode_in;
  logic [CW-1:0]         cnt, last_idx;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  relu_q;
  logic                  accept, bias_fire, acc_fire, drain_start, drain_rd, pop, room;
  logic [2:0]            occ_nxt;

  logic                  vld_p1, vld_p2, vld_p3;
  logic [BW-1:0]         bank_p1, bank_p2, bank_p3;
  logic [ADDR_WIDTH-1:0] addr_p1, addr_p2, addr_p3;
  logic signed [DW-1:0]  data_p1, sum_p2, sum_p3, old_p1;
  logic signed [63:0]    sum_w, relu_w;
  logic                  sat_w, hit_p2, hit_p3;

  logic                  rd_en, wr_en, rd_vld_q, rd_last_q;
  logic [BW-1:0]         rd_bank, wr_bank, rd_bank_q;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic signed [DW-1:0]  wr_data, rd_sel, push_data;
  logic signed [DW-1:0]  rd_word [NUM_BANKS];

  logic [1:0]            fcnt;
  logic signed [DW-1:0]  head_data, e1_data;
  logic                  head_last, e1_last;
  logic                  unused_bits;

  assign mode_in     = obuf_mode_e'(cmd_mode);
  assign accept      = (state == ST_IDLE) && cmd_valid && (mode_in != MODE_NONE);
  assign last_idx    = {len_q, {BW{1'b0}}} - CW'(1);
  assign busy        = (state != ST_IDLE);

  assign bus.s_bias_tready = (state == ST_BIAS);
  assign bus.acc_ready     = (state == ST_ACCUM);
  assign bias_fire   = bus.s_bias_tvalid && bus.s_bias_tready;
  assign acc_fire    = bus.acc_valid && bus.acc_ready;

  assign bus.m_tvalid = (fcnt != 2'd0);
  assign bus.m_tdata  = head_data;
  assign bus.m_tlast  = head_last && bus.m_tvalid;
  assign pop          = bus.m_tvalid && bus.m_tready;
  assign occ_nxt      = {1'b0, fcnt} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign room         = (occ_nxt < 3'd2);
  // Word 0 is fetched on the accept cycle itself so the stream starts one cycle sooner.
  assign drain_start  = accept && (mode_in == MODE_DRAIN);
  assign drain_rd     = (state == ST_DRAIN) && room;

  always_comb begin
    rd_en   = 1'b0;
    rd_bank = '0;
    rd_addr = '0;
    if (acc_fire) begin
      rd_en   = 1'b1;
      rd_bank = bus.acc_bank;
      rd_addr = bus.acc_addr;
    end else if (drain_start) begin
      rd_en   = 1'b1;
    end else if (drain_rd) begin
      rd_en   = 1'b1;
      rd_bank = cnt[BW-1:0];
      rd_addr = cnt[BW +: ADDR_WIDTH];
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_bank = '0;
    wr_addr = '0;
    wr_data = '0;
    if (bias_fire) begin
      wr_en   = 1'b1;
      wr_bank = cnt[BW-1:0];
      wr_addr = cnt[BW +: ADDR_WIDTH];
      wr_data = bus.s_bias_tdata;
    end else if (vld_p2) begin
      wr_en   = 1'b1;
      wr_bank = bank_p2;
      wr_addr = addr_p2;
      wr_data = sum_p2;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    obuf_bank_sdp #(.DW(DW), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .we_a    (wr_en && (wr_bank == BW'(b))),
      .addr_a  (wr_addr),
      .wdata_a (wr_data),
      .en_b    (rd_en && (rd_bank == BW'(b))),
      .addr_b  (rd_addr),
      .rdata_b (rd_word[b])
    );
  end

  assign rd_sel = rd_word[rd_bank_q];

  // p1 -> p2 boundary: youngest in-flight sum wins over the stale bank read.
  always_comb begin
    hit_p2 = vld_p2 && (bank_p2 == bank_p1) && (addr_p2 == addr_p1);
    hit_p3 = vld_p3 && (bank_p3 == bank_p1) && (addr_p3 == addr_p1);
    old_p1 = hit_p2 ? sum_p2 : (hit_p3 ? sum_p3 : rd_sel);
    sum_w  = sat_add(64'(old_p1), 64'(data_p1), DW, sat_w);
    relu_w = relu(64'(rd_sel));
  end

  assign push_data   = relu_q ? relu_w[DW-1:0] : rd_sel;
  assign unused_bits = ^{bus.s_bias_tlast, sum_w[63:DW], relu_w[63:DW]};

  always_ff @(posedge clk) begin
    if (acc_fire) begin
      bank_p1 <= bus.acc_bank;
      addr_p1 <= bus.acc_addr;
      data_p1 <= bus.acc_data;
    end
    bank_p2 <= bank_p1;
    addr_p2 <= addr_p1;
    sum_p2  <= sum_w[DW-1:0];
    bank_p3 <= bank_p2;
    addr_p3 <= addr_p2;
    sum_p3  <= sum_p2;
    if (rd_en) rd_bank_q <= rd_bank;
    if (rd_vld_q) begin
      e1_data <= push_data;
      e1_last <= rd_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      relu_q    <= 1'b0;
      done      <= 1'b0;
      err_sat   <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      fcnt      <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
    end else begin
      done      <= 1'b0;
      vld_p1    <= acc_fire;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      rd_vld_q  <= drain_start || drain_rd;
      rd_last_q <= drain_rd && (cnt == last_idx);
      if (vld_p1 && sat_w) err_sat <= 1'b1;

      fcnt <= fcnt + {1'b0, rd_vld_q} - {1'b0, pop};
      if (rd_vld_q && ((fcnt == 2'd0) || ((fcnt == 2'd1) && pop))) begin
        head_data <= push_data;
        head_last <= rd_last_q;
      end else if ((fcnt == 2'd2) && pop) begin
        head_data <= e1_data;
        head_last <= e1_last;
      end

      unique case (state)
        ST_IDLE: if (accept) begin
          len_q   <= cfg_len;
          relu_q  <= cfg_relu;
          err_sat <= 1'b0;
          cnt     <= (mode_in == MODE_DRAIN) ? CW'(1) : '0;
          case (mode_in)
            MODE_BIAS:  state <= ST_BIAS;
            MODE_ACCUM: state <= ST_ACCUM;
            default:    state <= ST_DRAIN;
          endcase
        end
        ST_BIAS: if (bias_fire) begin
          cnt <= cnt + CW'(1);
          if (cnt == last_idx) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_ACCUM: if (acc_end) begin
          state <= ST_ACC_FLUSH;
          cnt   <= '0;
        end
        ST_ACC_FLUSH: begin
          cnt <= cnt + CW'(1);
          if (cnt[0]) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_DRAIN: if (drain_rd) begin
          cnt <= cnt + CW'(1);
          if (cnt == last_idx) state <= ST_DRAIN_FLUSH;
        end
        ST_DRAIN_FLUSH: if ((fcnt == 2'd0) && !rd_vld_q) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_accum_buffer.sv
// Directed scoreboard bench for output_accum_buffer (16 banks x 512 x 16 bit).
module tb_output_accum_buffer;
  localparam int DW = 16;
  localparam int NB = 16;
  localparam int AW = 9;
  localparam int BW = 4;

  typedef struct { int data; bit last; } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid;
  logic [1:0]    cmd_mode;
  logic [AW:0]   cfg_len;
  logic          cfg_relu;
  logic          acc_end;
  logic          busy, done, err_sat;

  output_accum_buffer_if #(.DW(DW), .ADDR_WIDTH(AW), .BW(BW)) bus ();

  output_accum_buffer #(.DW(DW), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DEPTH(512)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cfg_len   (cfg_len),
    .cfg_relu  (cfg_relu),
    .acc_end   (acc_end),
    .busy      (busy),
    .done      (done),
    .err_sat   (err_sat),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   pop_cnt = 0;
  bit   rnd_rdy = 1'b0;
  bit   sess_err;
  int   mem_m [NB][512];
  exp_t exp_q [$];

  bit                   pv_stall = 1'b0;
  logic signed [DW-1:0] pv_data;
  logic                 pv_last;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input int x, output bit clamped);
    clamped = 1'b0;
    if (x > 32767) begin clamped = 1'b1; return 32767; end
    if (x < -32768) begin clamped = 1'b1; return -32768; end
    return x;
  endfunction

  // Scoreboard monitor: compares every accepted drain beat and checks stall stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_stall = 1'b0;
      end else begin
        if (pv_stall) begin
          check("hold_valid", bus.m_tvalid, 1);
          if (bus.m_tvalid) begin
            check("hold_data", $signed(bus.m_tdata), pv_data);
            check("hold_last", bus.m_tlast, pv_last);
          end
        end
        if (bus.m_tvalid && bus.m_tready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got %0d, expected no output", $signed(bus.m_tdata));
          end else begin
            e = exp_q.pop_front();
            check("drain_data", $signed(bus.m_tdata), e.data);
            check("drain_last", bus.m_tlast, e.last);
          end
          pop_cnt++;
        end
        pv_stall = bus.m_tvalid && !bus.m_tready;
        pv_data  = bus.m_tdata;
        pv_last  = bus.m_tlast;
      end
    end
  end

  initial begin
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_cmd(input int mode, input int len, input bit relu);
    cmd_valid = 1'b1;
    cmd_mode  = 2'(mode);
    cfg_len   = (AW+1)'(len);
    cfg_relu  = relu;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    check("busy_after_cmd", busy, 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    check(name, done, 1);
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic push_bias(input int v, input bit last);
    int n = 0;
    bus.s_bias_tdata  = DW'(v);
    bus.s_bias_tlast  = last;
    bus.s_bias_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.s_bias_tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL bias_tready: got 0, expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.s_bias_tvalid = 1'b0;
  endtask

  task automatic do_bias(input int len);
    send_cmd(1, len, 1'b0);
    for (int n = 0; n < NB * len; n++) push_bias(mem_m[n % NB][n / NB], n == NB * len - 1);
    wait_done("bias_done");
  endtask

  task automatic do_drain(input int len, input bit relu);
    for (int n = 0; n < NB * len; n++) begin
      int v = mem_m[n % NB][n / NB];
      if (relu && v < 0) v = 0;
      exp_q.push_back('{data: v, last: (n == NB * len - 1)});
    end
    send_cmd(3, len, relu);
    @(posedge clk);
    #1;
    check("drain_first_valid", bus.m_tvalid, 1);
    wait_done("drain_done");
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic acc_upd(input int b, input int a, input int d);
    int n = 0;
    bit c;
    bus.acc_valid = 1'b1;
    bus.acc_bank  = BW'(b);
    bus.acc_addr  = AW'(a);
    bus.acc_data  = DW'(d);
    @(negedge clk);
    while (!bus.acc_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL acc_ready: got 0, expected 1 within 20 cycles");
    end
    mem_m[b][a] = sat16(mem_m[b][a] + d, c);
    sess_err |= c;
    @(posedge clk);
    #1;
    bus.acc_valid = 1'b0;
  endtask

  task automatic acc_finish();
    acc_end = 1'b1;
    @(posedge clk);
    #1;
    acc_end = 1'b0;
    check("acc_ready_drop", bus.acc_ready, 0);
    wait_done("acc_done");
  endtask

  initial begin
    int base, n;
    cmd_valid = 1'b0; cmd_mode = 2'd0; cfg_len = '0; cfg_relu = 1'b0; acc_end = 1'b0;
    bus.s_bias_tdata = '0; bus.s_bias_tvalid = 1'b0; bus.s_bias_tlast = 1'b0;
    bus.acc_valid = 1'b0; bus.acc_bank = '0; bus.acc_addr = '0; bus.acc_data = '0;
    for (int b = 0; b < NB; b++) for (int a = 0; a < 512; a++) mem_m[b][a] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_sat", err_sat, 0);
    check("rst_acc_ready", bus.acc_ready, 0);
    check("rst_bias_tready", bus.s_bias_tready, 0);
    check("rst_m_tvalid", bus.m_tvalid, 0);
    check("rst_m_tlast", bus.m_tlast, 0);
    check("rst_m_tdata", $signed(bus.m_tdata), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Linear bias 0..63 then drain back in the same order.
    for (int i = 0; i < 64; i++) mem_m[i % NB][i / NB] = i;
    do_bias(4);
    do_drain(4, 1'b0);

    // Three back-to-back +5 updates to one location: 100 -> 115.
    for (int i = 0; i < 128; i++) mem_m[i % NB][i / NB] = i - 40;
    mem_m[3][7] = 100;
    do_bias(8);
    send_cmd(2, 1, 1'b0);
    sess_err = 1'b0;
    acc_upd(3, 7, 5);
    acc_upd(3, 7, 5);
    acc_upd(3, 7, 5);
    acc_finish();
    check("entry_3_7_model", mem_m[3][7], 115);
    check("err_sat_clean", err_sat, 0);
    do_drain(8, 1'b0);

    // Saturation at both rails.
    for (int b = 0; b < NB; b++) mem_m[b][0] = b * 3;
    mem_m[0][0] = 32760;
    mem_m[1][0] = -32760;
    do_bias(1);
    send_cmd(2, 1, 1'b0);
    acc_upd(0, 0, 20);
    acc_finish();
    check("err_sat_pos", err_sat, 1);
    send_cmd(2, 1, 1'b0);
    check("err_sat_cleared_on_cmd", err_sat, 0);
    acc_upd(1, 0, -20);
    acc_finish();
    check("err_sat_neg", err_sat, 1);
    do_drain(1, 1'b0);
    check("err_sat_after_drain", err_sat, 0);

    // ReLU drain over {-4, 0, 9, ...}, then with random backpressure.
    for (int b = 0; b < NB; b++) begin
      mem_m[b][0] = b * 3 - 20;
      mem_m[b][1] = 7 - b * 5;
    end
    mem_m[0][0] = -4;
    mem_m[1][0] = 0;
    mem_m[2][0] = 9;
    do_bias(2);
    do_drain(1, 1'b1);
    rnd_rdy = 1'b1;
    do_drain(2, 1'b1);
    do_drain(2, 1'b0);
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;

    // Interleaved banks 0/1 at one address every cycle.
    for (int i = 0; i < 96; i++) mem_m[i % NB][i / NB] = (i * 7) % 50 - 25;
    do_bias(6);
    send_cmd(2, 1, 1'b0);
    sess_err = 1'b0;
    acc_upd(0, 5, 3);
    acc_upd(1, 5, -7);
    acc_upd(0, 5, 11);
    acc_upd(1, 5, 2);
    acc_upd(0, 5, -1);
    acc_upd(1, 5, 4);
    acc_upd(0, 5, 30000);
    acc_upd(0, 5, 30000);
    acc_finish();
    check("err_sat_interleave", err_sat, 32'(sess_err));
    do_drain(6, 1'b0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 64; i++) mem_m[i % NB][i / NB] = i * 5 - 100;
    do_bias(4);
    for (int i = 0; i < 64; i++) exp_q.push_back('{data: mem_m[i % NB][i / NB], last: (i == 63)});
    send_cmd(3, 4, 1'b0);
    base = pop_cnt;
    n = 0;
    while (pop_cnt - base < 5 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("mid_drain_words", pop_cnt - base >= 5, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err_sat", err_sat, 0);
    check("mrst_acc_ready", bus.acc_ready, 0);
    check("mrst_bias_tready", bus.s_bias_tready, 0);
    check("mrst_m_tvalid", bus.m_tvalid, 0);
    check("mrst_m_tlast", bus.m_tlast, 0);
    check("mrst_m_tdata", $signed(bus.m_tdata), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int b = 0; b < NB; b++) mem_m[b][0] = b - 8;
    do_bias(1);
    do_drain(1, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
